// File: rtl/conv_accumulator.sv
// Streaming convolution-window accumulator: sums KSIZE Q16.16 products, then
// rescales to Q8.8 with saturation and optional ReLU, held until consumed.
module conv_accumulator #(
   parameter int unsigned KSIZE = 25,
   parameter int unsigned FRAC  = 8,
   parameter int unsigned ACC_W = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] product,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        relu_en,
   output logic [15:0] result,
   output logic        sat,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned PROD_W = 32;
   localparam int unsigned RES_W  = 16;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned HI_W   = ACC_W - RES_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KSIZE - 1);

   logic [1:0]        r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [RES_W-1:0]  r_result;
   logic              r_sat;
   logic              r_out_valid;
   logic              r_in_ready;

   logic [1:0]        w_state_nxt;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [RES_W-1:0]  w_result_nxt;
   logic              w_sat_nxt;
   logic              w_out_valid_nxt;
   logic              w_in_ready_nxt;

   logic [ACC_W-1:0]  w_prod_ext;
   logic [ACC_W-1:0]  w_sum;
   logic [ACC_W-1:0]  w_shift;
   logic [HI_W-1:0]   w_hi;
   logic              w_ovf;
   logic [RES_W-1:0]  w_clip;
   logic [RES_W-1:0]  w_final;

   // Datapath: a window in IDLE starts from zero, so the stale acc never leaks in.
   always_comb begin
      w_prod_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
      w_sum      = ((r_state == S_IDLE) ? '0 : r_acc) + w_prod_ext;
      w_shift    = ACC_W'($signed(w_sum) >>> FRAC);
      // Fits in 16 bits only if everything from bit 15 upward is a pure sign extension.
      w_hi       = w_shift[ACC_W-1:RES_W-1];
      w_ovf      = !((&w_hi) || (~|w_hi));
      if (w_ovf) begin
         w_clip = w_shift[ACC_W-1] ? 16'h8000 : 16'h7FFF;
      end else begin
         w_clip = w_shift[RES_W-1:0];
      end
      w_final = (relu_en && w_clip[RES_W-1]) ? '0 : w_clip;
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_result_nxt    = r_result;
      w_sat_nxt       = r_sat;
      w_out_valid_nxt = r_out_valid;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_acc_nxt   = w_sum;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               if (r_cnt == CNT_LAST) begin
                  w_result_nxt    = w_final;
                  w_sat_nxt       = w_ovf;
                  w_out_valid_nxt = 1'b1;
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = S_HOLD;
               end else begin
                  w_acc_nxt = w_sum;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt     = S_IDLE;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
         end
      endcase

      w_in_ready_nxt = (w_state_nxt != S_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_result    <= w_result_nxt;
         r_sat       <= w_sat_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign result    = r_result;
   assign sat       = r_sat;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed plus randomized windows for conv_accumulator (KSIZE=4, FRAC=8),
// checked against an arithmetic reference of the window sum.
module tb_conv_accumulator;

   localparam int unsigned KSIZE = 4;
   localparam int unsigned FRAC  = 8;
   localparam int unsigned ACC_W = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] product = '0;
   logic        in_valid = 1'b0;
   logic        relu_en = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic [15:0] result;
   logic        sat;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] win[$];

   conv_accumulator #(.KSIZE(KSIZE), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .product   (product),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .relu_en   (relu_en),
      .result    (result),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: Q16.16 sum -> floor divide by 2^FRAC -> clip -> optional ReLU. Returns {sat, result}.
   function automatic logic [16:0] model(input longint sum, input logic relu);
      longint      q;
      logic [15:0] r;
      logic        s;
      q = sum >>> FRAC;
      if (q > 32767) begin
         r = 16'h7FFF; s = 1'b1;
      end else if (q < -32768) begin
         r = 16'h8000; s = 1'b1;
      end else begin
         r = 16'(q); s = 1'b0;
      end
      if (relu && q < 0) r = 16'h0000;
      return {s, r};
   endfunction

   task automatic xfer(input logic [31:0] p, input logic relu);
      product  = p;
      in_valid = 1'b1;
      relu_en  = relu;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      relu_en  = ~relu;
   endtask

   // Sends the window in 'win'; relu_en is inverted on non-final beats so only the final sample matters.
   task automatic run_window(input string tag, input logic relu, input int gap_max, input int hold,
                             input logic use_c, input logic [15:0] c_res, input logic c_sat);
      longint      sum;
      logic [16:0] exp;
      int          n;
      sum = 0;
      n   = win.size();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge clk);
            #1;
         end
         if (i == n - 1) begin
            chk({tag, "_ov_pre"}, 32'(out_valid), 32'd0);
            chk({tag, "_ir_pre"}, 32'(in_ready), 32'd1);
         end
         xfer(win[i], (i == n - 1) ? relu : ~relu);
         sum += longint'($signed(win[i]));
      end
      exp = model(sum, relu);
      chk({tag, "_ov"},  32'(out_valid), 32'd1);
      chk({tag, "_res"}, 32'(result), 32'(exp[15:0]));
      chk({tag, "_sat"}, 32'(sat), 32'(exp[16]));
      chk({tag, "_ir_hold"}, 32'(in_ready), 32'd0);
      if (use_c) begin
         chk({tag, "_res_c"}, 32'(result), 32'(c_res));
         chk({tag, "_sat_c"}, 32'(sat), 32'(c_sat));
      end
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         product  = $urandom;
         @(posedge clk);
         #1;
         chk({tag, "_hold_ov"},  32'(out_valid), 32'd1);
         chk({tag, "_hold_res"}, 32'(result), 32'(exp[15:0]));
         chk({tag, "_hold_sat"}, 32'(sat), 32'(exp[16]));
         chk({tag, "_hold_ir"},  32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_ov_done"}, 32'(out_valid), 32'd0);
      chk({tag, "_ir_done"}, 32'(in_ready), 32'd1);
   endtask

   task automatic fill(input logic [31:0] v);
      win = {v, v, v, v};
   endtask

   function automatic logic [31:0] rand_prod();
      case ($urandom_range(3, 0))
         0:       return $urandom;
         1:       return 32'($urandom_range(200000, 0)) - 32'd100000;
         2:       return ($urandom_range(1, 0) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
         default: return 32'($urandom_range(20000000, 0)) - 32'd10000000;
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov",  32'(out_valid), 32'd0);
      chk("rst_res", 32'(result), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ir", 32'(in_ready), 32'd1);

      win = {32'd1200, 32'd360, 32'd2550, 32'd0};
      run_window("basic", 1'b0, 0, 0, 1'b1, 16'd16, 1'b0);

      fill(32'hFFFF_FE00);
      run_window("neg", 1'b0, 1, 1, 1'b1, 16'hFFF8, 1'b0);
      fill(32'hFFFF_FE00);
      run_window("neg_relu", 1'b1, 1, 0, 1'b1, 16'h0000, 1'b0);

      fill(32'h7FFF_FFFF);
      run_window("sat_pos", 1'b0, 0, 0, 1'b1, 16'h7FFF, 1'b1);
      fill(32'h8000_0000);
      run_window("sat_neg", 1'b0, 0, 0, 1'b1, 16'h8000, 1'b1);
      fill(32'h8000_0000);
      run_window("sat_neg_relu", 1'b1, 0, 0, 1'b1, 16'h0000, 1'b1);

      win = {32'd100, 32'd200, 32'd300, 32'd400};
      run_window("bp", 1'b0, 0, 5, 1'b1, 16'd3, 1'b0);
      fill(32'd256);
      run_window("bp_next", 1'b0, 0, 0, 1'b1, 16'd4, 1'b0);

      xfer(32'd1000, 1'b0);
      xfer(32'd1000, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_ir", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fill(32'd256);
      run_window("mid_rst", 1'b0, 0, 0, 1'b1, 16'd4, 1'b0);

      fill(32'hFFFF_FFFF);
      run_window("trunc", 1'b0, 0, 0, 1'b1, 16'hFFFF, 1'b0);

      for (int i = 0; i < KSIZE; i++) xfer(32'h7FFF_FFFF, 1'b0);
      chk("hold_rst_pre_ov", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("hold_rst_ov",  32'(out_valid), 32'd0);
      chk("hold_rst_res", 32'(result), 32'd0);
      chk("hold_rst_sat", 32'(sat), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("hold_rst_ir", 32'(in_ready), 32'd1);

      for (int w = 0; w < 40; w++) begin
         win = {};
         for (int k = 0; k < KSIZE; k++) win.push_back(rand_prod());
         run_window("rand", 1'($urandom_range(1, 0)), 2, $urandom_range(3, 0), 1'b0, 16'h0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
